// File: rtl/ap_phase_sequencer.sv
// Sequences NUM_PHASES child blocks over ap_ctrl_hs handshakes for a programmable
// number of iterations, with saturating per-phase and total busy-cycle counters.
module ap_phase_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int ITER_W     = 16,
    parameter int CNT_W      = 32,
    localparam int PH_W      = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        ap_start,
    input  logic [ITER_W-1:0]           num_iters,
    output logic                        ap_done,
    output logic                        ap_ready,
    output logic                        ap_idle,
    output logic [NUM_PHASES-1:0]       child_start,
    input  logic [NUM_PHASES-1:0]       child_ready,
    input  logic [NUM_PHASES-1:0]       child_done,
    output logic [PH_W-1:0]             cur_phase,
    output logic [ITER_W-1:0]           iter_idx,
    output logic [NUM_PHASES*CNT_W-1:0] phase_cycles,
    output logic [CNT_W-1:0]            total_cycles,
    output logic                        proto_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    logic [1:0]            state_r, state_nx_s, adv_state_s;
    logic [PH_W-1:0]       cur_phase_r, phase_nx_s, adv_phase_s;
    logic [ITER_W-1:0]     iter_idx_r, iter_nx_s, adv_iter_s;
    logic [ITER_W-1:0]     num_iters_r;
    logic [CNT_W-1:0]      total_cnt_r;
    logic [CNT_W-1:0]      phase_cnt_r [NUM_PHASES];
    logic                  proto_err_r;
    logic [NUM_PHASES-1:0] active_mask_s;
    logic                  ready_act_s, done_act_s, other_s, viol_s;
    logic                  accept_s, busy_s, last_phase_s, last_iter_s;

    assign active_mask_s = NUM_PHASES'(1) << cur_phase_r;
    assign ready_act_s   = |(child_ready & active_mask_s);
    assign done_act_s    = |(child_done & active_mask_s);
    assign other_s       = |((child_ready | child_done) & ~active_mask_s);
    assign accept_s      = (state_r == S_IDLE) && ap_start;
    assign busy_s        = (state_r == S_RUN) || (state_r == S_WAIT);
    assign last_phase_s  = (cur_phase_r == PH_W'(NUM_PHASES - 1));
    assign last_iter_s   = ((iter_idx_r + ITER_W'(1)) == num_iters_r);

    // Target of an ADVANCE: next phase, next iteration, or finish.
    always_comb begin
        adv_state_s = S_FIN;
        adv_phase_s = cur_phase_r;
        adv_iter_s  = iter_idx_r;
        if (!last_phase_s) begin
            adv_phase_s = cur_phase_r + PH_W'(1);
            adv_state_s = S_RUN;
        end else if (!last_iter_s) begin
            adv_iter_s  = iter_idx_r + ITER_W'(1);
            adv_phase_s = {PH_W{1'b0}};
            adv_state_s = S_RUN;
        end else begin
            adv_state_s = S_FIN;
        end
    end

    // Next-state decode; only handshakes of the active phase move the sequence.
    always_comb begin
        state_nx_s = state_r;
        phase_nx_s = cur_phase_r;
        iter_nx_s  = iter_idx_r;
        case (state_r)
            S_IDLE: begin
                if (ap_start) begin
                    phase_nx_s = {PH_W{1'b0}};
                    iter_nx_s  = {ITER_W{1'b0}};
                    state_nx_s = (num_iters == {ITER_W{1'b0}}) ? S_FIN : S_RUN;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (ready_act_s && done_act_s) begin
                    state_nx_s = adv_state_s;
                    phase_nx_s = adv_phase_s;
                    iter_nx_s  = adv_iter_s;
                end else if (ready_act_s) begin
                    state_nx_s = S_WAIT;
                end else begin
                    state_nx_s = S_RUN;
                end
            end
            S_WAIT: begin
                if (done_act_s) begin
                    state_nx_s = adv_state_s;
                    phase_nx_s = adv_phase_s;
                    iter_nx_s  = adv_iter_s;
                end else begin
                    state_nx_s = S_WAIT;
                end
            end
            S_FIN:   state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Protocol violations: stray child bits, or done before ready on the active phase.
    always_comb begin
        viol_s = 1'b0;
        case (state_r)
            S_IDLE:  viol_s = |(child_ready | child_done);
            S_RUN:   viol_s = other_s | (done_act_s & ~ready_act_s);
            S_WAIT:  viol_s = other_s;
            S_FIN:   viol_s = |(child_ready | child_done);
            default: viol_s = 1'b0;
        endcase
    end

    // Sequencer state, phase/iteration indices and latched iteration count.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_r     <= S_IDLE;
            cur_phase_r <= {PH_W{1'b0}};
            iter_idx_r  <= {ITER_W{1'b0}};
            num_iters_r <= {ITER_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            cur_phase_r <= phase_nx_s;
            iter_idx_r  <= iter_nx_s;
            if (accept_s) begin
                num_iters_r <= num_iters;
            end else begin
                num_iters_r <= num_iters_r;
            end
        end
    end

    // Busy-cycle counters and sticky error; cleared on accept, held while idle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            total_cnt_r <= {CNT_W{1'b0}};
            proto_err_r <= 1'b0;
            for (int p = 0; p < NUM_PHASES; p++) begin
                phase_cnt_r[p] <= {CNT_W{1'b0}};
            end
        end else if (accept_s) begin
            total_cnt_r <= {CNT_W{1'b0}};
            proto_err_r <= viol_s;
            for (int p = 0; p < NUM_PHASES; p++) begin
                phase_cnt_r[p] <= {CNT_W{1'b0}};
            end
        end else begin
            proto_err_r <= proto_err_r | viol_s;
            if (state_r != S_IDLE) begin
                total_cnt_r <= sat_inc(total_cnt_r);
            end
            for (int p = 0; p < NUM_PHASES; p++) begin
                if (busy_s && (cur_phase_r == PH_W'(p))) begin
                    phase_cnt_r[p] <= sat_inc(phase_cnt_r[p]);
                end
            end
        end
    end

    assign ap_idle      = (state_r == S_IDLE);
    assign ap_done      = (state_r == S_FIN);
    assign ap_ready     = (state_r == S_FIN);
    assign child_start  = (state_r == S_RUN) ? active_mask_s : {NUM_PHASES{1'b0}};
    assign cur_phase    = cur_phase_r;
    assign iter_idx     = iter_idx_r;
    assign total_cycles = total_cnt_r;
    assign proto_err    = proto_err_r;

    for (genvar p = 0; p < NUM_PHASES; p++) begin : g_phase_out
        assign phase_cycles[p*CNT_W +: CNT_W] = phase_cnt_r[p];
    end

endmodule

// File: tb/tb_ap_phase_sequencer.sv
// Self-checking bench for ap_phase_sequencer: cycle-level expectations derived from
// per-handshake child latencies (ready delay r, done delay d -> phase time r+1+d).
module tb_ap_phase_sequencer;
    localparam int NP = 4;
    localparam int IW = 16;
    localparam int CW = 32;

    logic ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic           ap_rst_n, ap_start, ap_done, ap_ready, ap_idle, proto_err;
    logic [IW-1:0]  num_iters, iter_idx;
    logic [NP-1:0]  child_start, child_ready, child_done;
    logic [1:0]     cur_phase;
    logic [NP*CW-1:0] phase_cycles;
    logic [CW-1:0]  total_cycles;

    // Small second instance for counter saturation
    logic       s_start, s_done, s_ready, s_idle, s_err, s_cstart, s_cready, s_cdone, s_phase;
    logic [3:0] s_num_iters, s_iter_idx, s_phase_cycles, s_total;

    int checks = 0;
    int errors = 0;
    int exp_ph[NP];
    int exp_tot;

    ap_phase_sequencer #(.NUM_PHASES(NP), .ITER_W(IW), .CNT_W(CW)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .num_iters(num_iters),
        .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle),
        .child_start(child_start), .child_ready(child_ready), .child_done(child_done),
        .cur_phase(cur_phase), .iter_idx(iter_idx), .phase_cycles(phase_cycles),
        .total_cycles(total_cycles), .proto_err(proto_err)
    );

    ap_phase_sequencer #(.NUM_PHASES(1), .ITER_W(4), .CNT_W(4)) dut_sat (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(s_start), .num_iters(s_num_iters),
        .ap_done(s_done), .ap_ready(s_ready), .ap_idle(s_idle),
        .child_start(s_cstart), .child_ready(s_cready), .child_done(s_cdone),
        .cur_phase(s_phase), .iter_idx(s_iter_idx), .phase_cycles(s_phase_cycles),
        .total_cycles(s_total), .proto_err(s_err)
    );

    // One full run; children respond after r cycles with ready and d cycles later with done.
    task automatic run_and_check(input string name, input int iters, input int rmin, input int rmax,
                                 input int dmin, input int dmax, input int stall_p, input int stall_n);
        int r, d;
        for (int p = 0; p < NP; p++) exp_ph[p] = 0;
        exp_tot = 0;
        @(negedge ap_clk);
        checks++;
        if (ap_idle !== 1'b1) begin
            errors++; $display("FAIL %s idle_before got %b exp 1", name, ap_idle);
        end
        ap_start = 1'b1; num_iters = IW'(iters);
        @(negedge ap_clk);
        ap_start = 1'b0;
        for (int i = 0; i < iters; i++) begin
            for (int p = 0; p < NP; p++) begin
                r = (p == stall_p) ? stall_n : int'($urandom_range(rmax, rmin));
                d = int'($urandom_range(dmax, dmin));
                for (int t = 0; t <= r; t++) begin
                    checks++;
                    if (child_start !== NP'(1 << p) || cur_phase !== 2'(p) || iter_idx !== IW'(i)
                        || ap_idle !== 1'b0 || ap_done !== 1'b0) begin
                        errors++;
                        $display("FAIL %s run i=%0d p=%0d t=%0d got start=%b phase=%0d iter=%0d idle=%b done=%b exp start=%b",
                                 name, i, p, t, child_start, cur_phase, iter_idx, ap_idle, ap_done, NP'(1 << p));
                    end
                    if (t == r) begin
                        child_ready[p] = 1'b1;
                        if (d == 0) child_done[p] = 1'b1;
                    end
                    @(negedge ap_clk);
                    child_ready = '0; child_done = '0;
                end
                for (int t = 1; t <= d; t++) begin
                    checks++;
                    if (child_start !== '0 || cur_phase !== 2'(p) || ap_done !== 1'b0) begin
                        errors++;
                        $display("FAIL %s wait i=%0d p=%0d t=%0d got start=%b phase=%0d done=%b exp start=0 phase=%0d",
                                 name, i, p, t, child_start, cur_phase, ap_done, p);
                    end
                    if (t == d) child_done[p] = 1'b1;
                    @(negedge ap_clk);
                    child_done = '0;
                end
                exp_ph[p] += r + 1 + d;
                exp_tot   += r + 1 + d;
            end
        end
        exp_tot += 1;
        checks++;
        if (ap_done !== 1'b1 || ap_ready !== 1'b1 || child_start !== '0 || ap_idle !== 1'b0) begin
            errors++;
            $display("FAIL %s fin got done=%b ready=%b start=%b idle=%b exp 1 1 0000 0",
                     name, ap_done, ap_ready, child_start, ap_idle);
        end
        @(negedge ap_clk);
        checks++;
        if (ap_done !== 1'b0 || ap_ready !== 1'b0 || ap_idle !== 1'b1) begin
            errors++;
            $display("FAIL %s after_fin got done=%b ready=%b idle=%b exp 0 0 1", name, ap_done, ap_ready, ap_idle);
        end
        checks++;
        if (total_cycles !== CW'(exp_tot)) begin
            errors++; $display("FAIL %s total_cycles got %0d exp %0d", name, total_cycles, exp_tot);
        end
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (phase_cycles[p*CW +: CW] !== CW'(exp_ph[p])) begin
                errors++;
                $display("FAIL %s phase_cycles[%0d] got %0d exp %0d", name, p, phase_cycles[p*CW +: CW], exp_ph[p]);
            end
        end
        checks++;
        if (proto_err !== 1'b0) begin
            errors++; $display("FAIL %s proto_err got %b exp 0", name, proto_err);
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0; ap_start = 1'b0; num_iters = '0; child_ready = '0; child_done = '0;
        s_start = 1'b0; s_num_iters = '0; s_cready = 1'b0; s_cdone = 1'b0;
        #12;
        checks++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0 || ap_ready !== 1'b0 || child_start !== '0 || cur_phase !== '0
            || iter_idx !== '0 || phase_cycles !== '0 || total_cycles !== '0 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got idle=%b done=%b start=%b phase=%0d iter=%0d total=%0d err=%b",
                     ap_idle, ap_done, child_start, cur_phase, iter_idx, total_cycles, proto_err);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    task automatic test_zero_iters();
        @(negedge ap_clk);
        ap_start = 1'b1; num_iters = '0;
        @(negedge ap_clk);
        ap_start = 1'b0;
        checks++;
        if (ap_done !== 1'b1 || ap_ready !== 1'b1 || ap_idle !== 1'b0 || child_start !== '0) begin
            errors++;
            $display("FAIL zero_iters fin got done=%b ready=%b idle=%b start=%b exp 1 1 0 0000",
                     ap_done, ap_ready, ap_idle, child_start);
        end
        @(negedge ap_clk);
        checks++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0 || total_cycles !== CW'(1) || child_start !== '0) begin
            errors++;
            $display("FAIL zero_iters after got idle=%b done=%b total=%0d exp 1 0 1", ap_idle, ap_done, total_cycles);
        end
    endtask

    task automatic test_proto_err_reset();
        @(negedge ap_clk);
        ap_start = 1'b1; num_iters = IW'(1);
        @(negedge ap_clk);
        ap_start = 1'b0; child_ready[0] = 1'b1; child_done[0] = 1'b1;
        @(negedge ap_clk);
        child_ready = '0; child_done = '0;
        child_done[3] = 1'b1;
        @(negedge ap_clk);
        child_done = '0;
        checks++;
        if (proto_err !== 1'b1 || child_start !== 4'b0010 || cur_phase !== 2'd1) begin
            errors++;
            $display("FAIL proto_err_spurious got err=%b start=%b phase=%0d exp 1 0010 1", proto_err, child_start, cur_phase);
        end
        child_ready[1] = 1'b1;
        @(negedge ap_clk);
        child_ready = '0;
        checks++;
        if (child_start !== '0 || cur_phase !== 2'd1 || proto_err !== 1'b1) begin
            errors++;
            $display("FAIL proto_err_wait got start=%b phase=%0d err=%b exp 0000 1 1", child_start, cur_phase, proto_err);
        end
        #1 ap_rst_n = 1'b0;
        #1;
        checks++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0 || child_start !== '0 || cur_phase !== '0 || iter_idx !== '0
            || phase_cycles !== '0 || total_cycles !== '0 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got idle=%b start=%b phase=%0d total=%0d err=%b",
                     ap_idle, child_start, cur_phase, total_cycles, proto_err);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        run_and_check("after_reset", 1, 0, 0, 0, 0, -1, 0);
    endtask

    task automatic test_back_to_back();
        @(negedge ap_clk);
        ap_start = 1'b1; num_iters = '0;
        @(negedge ap_clk);
        checks++;
        if (ap_done !== 1'b1) begin
            errors++; $display("FAIL b2b_first_done got %b exp 1", ap_done);
        end
        @(negedge ap_clk);
        checks++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got idle=%b done=%b exp 1 0", ap_idle, ap_done);
        end
        num_iters = IW'(1);
        @(negedge ap_clk);
        ap_start = 1'b0;
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (child_start !== NP'(1 << p) || ap_idle !== 1'b0) begin
                errors++;
                $display("FAIL b2b_run p=%0d got start=%b idle=%b exp start=%b", p, child_start, ap_idle, NP'(1 << p));
            end
            child_ready[p] = 1'b1; child_done[p] = 1'b1;
            @(negedge ap_clk);
            child_ready = '0; child_done = '0;
        end
        checks++;
        if (ap_done !== 1'b1) begin
            errors++; $display("FAIL b2b_second_done got %b exp 1", ap_done);
        end
        @(negedge ap_clk);
        checks++;
        if (total_cycles !== CW'(5) || ap_idle !== 1'b1) begin
            errors++; $display("FAIL b2b_total got %0d idle=%b exp 5 1", total_cycles, ap_idle);
        end
    endtask

    task automatic test_saturation();
        @(negedge ap_clk);
        s_start = 1'b1; s_num_iters = 4'd1;
        @(negedge ap_clk);
        s_start = 1'b0;
        checks++;
        if (s_cstart !== 1'b1) begin
            errors++; $display("FAIL sat_start got %b exp 1", s_cstart);
        end
        s_cready = 1'b1;
        @(negedge ap_clk);
        s_cready = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            if (t == 20) begin
                checks++;
                if (s_phase_cycles !== 4'd15) begin
                    errors++; $display("FAIL sat_mid phase_cycles got %0d exp 15", s_phase_cycles);
                end
                s_cdone = 1'b1;
            end
            @(negedge ap_clk);
            s_cdone = 1'b0;
        end
        checks++;
        if (s_done !== 1'b1) begin
            errors++; $display("FAIL sat_done got %b exp 1", s_done);
        end
        @(negedge ap_clk);
        checks++;
        if (s_phase_cycles !== 4'd15 || s_total !== 4'd15 || s_idle !== 1'b1) begin
            errors++;
            $display("FAIL sat_final got phase=%0d total=%0d idle=%b exp 15 15 1", s_phase_cycles, s_total, s_idle);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            run_and_check("random", int'($urandom_range(4, 1)), 0, 3, 0, 3, -1, 0);
        end
    endtask

    initial begin
        test_reset();
        run_and_check("single_iter", 1, 1, 1, 3, 3, -1, 0);
        run_and_check("three_iters", 3, 0, 0, 0, 0, -1, 0);
        test_zero_iters();
        run_and_check("stall_p2", 1, 0, 0, 1, 2, 2, 10);
        test_proto_err_reset();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ap_phase_sequencer.md
# ap_phase_sequencer

Top-level phase controller for the kernel's pipelined sub-blocks (load, compute, accumulate, store). It exposes a standard ap_ctrl_hs start/done/idle/ready handshake upward and launches NUM_PHASES child blocks strictly in order, each through its own ap_ctrl_hs handshake, repeating the phase sequence for a programmable iteration count. It also keeps per-phase and total busy-cycle counters, so simulation monitors and software can read latency without probing child FSMs.

## Interface
- NUM_PHASES, 4: number of child blocks sequenced; minimum 1.
- ITER_W, 16: width of iteration count.
- CNT_W, 32: width of each cycle counter.

- ap_clk  in  1  clock; all state changes on rising edge.
- ap_rst_n  in  1  one clock; reset is asynchronous and active-low.
- ap_start  in  1  top-level start request (level, ap_ctrl_hs).
- num_iters  in  ITER_W  iteration count; sampled when ap_start is accepted.
- ap_done  out  1  one-cycle pulse when the whole run ends.
- ap_ready  out  1  one-cycle pulse coincident with ap_done.
- ap_idle  out  1  high while in IDLE.
- child_start  out  NUM_PHASES  one-hot start to child p.
- child_ready  in  NUM_PHASES  child ap_ready.
- child_done  in  NUM_PHASES  child ap_done.
- cur_phase  out  $clog2(NUM_PHASES) (min 1)  index of the active phase.
- iter_idx  out  ITER_W  index of the active iteration.
- phase_cycles  out  NUM_PHASES*CNT_W  per-phase accumulated busy cycles; phase p occupies bits [p*CNT_W +: CNT_W].
- total_cycles  out  CNT_W  cycles from accept to ap_done.
- proto_err  out  1  sticky protocol-violation flag.

## Operation
- States: IDLE, RUN (child_start[cur_phase] high, waiting child_ready), WAIT (waiting child_done), FIN.
- IDLE:
  - ap_idle=1.
  - When ap_start=1, latch num_iters and clear all counters, proto_err, cur_phase and iter_idx.
  - If the latched num_iters=0, go to FIN. Otherwise go to RUN with phase 0.
- RUN: child_start is driven only for cur_phase.
  - child_ready[cur_phase] and child_done[cur_phase] both high: ADVANCE.
  - child_ready[cur_phase] high alone: go to WAIT.
  - Otherwise: stay in RUN.
- WAIT:
  - child_start=0.
  - child_done[cur_phase] high: ADVANCE.
- ADVANCE (transition action, not a state):
  - If cur_phase<NUM_PHASES-1: increment cur_phase and go to RUN.
  - Else if iter_idx<num_iters-1: increment iter_idx, set cur_phase=0 and go to RUN.
  - Else: go to FIN.
- FIN: ap_done=1 and ap_ready=1 for exactly one cycle, then IDLE.
- Counters:
  - total_cycles increments every cycle in RUN, WAIT and FIN.
  - phase_cycles[cur_phase] increments every cycle in RUN or WAIT.
  - All counters saturate at all-ones and never wrap.
- Counters and proto_err hold their values in IDLE until the next accepted start.
- proto_err is set by any of:
  - child_done[cur_phase] in RUN without child_ready[cur_phase];
  - any child_ready or child_done bit of a non-active phase while in RUN or WAIT;
  - any child bit in IDLE or FIN.
- Violating inputs are otherwise ignored; the sequence does not advance on them.
- ap_start is ignored outside IDLE.

## Timing
- Reset values: state IDLE; ap_idle=1; ap_done=0; ap_ready=0; child_start=0; cur_phase=0; iter_idx=0; all counters 0; proto_err=0. Reset takes effect immediately, including mid-run; child_start drops with no clock edge.
- All outputs are registered or decoded from registered state only; there is no combinational input-to-output path.
- Start latency: ap_start sampled at edge k puts child_start[0]=1 in cycle k+1.
- Inter-phase gap is zero: child_done[p] sampled at edge j gives child_start[p+1]=1 in cycle j+1.
- child_start[p] stays high until the edge that samples child_ready[p]=1, and is low in the following cycle.
- ap_done/ap_ready are high in the cycle after the last child_done. ap_idle rises in the cycle after that.
- num_iters=0: ap_start at edge k gives ap_done in cycle k+1 and no child_start. total_cycles=1.
- Back-to-back runs: if ap_start is still high in the first IDLE cycle after FIN, a new run is accepted at that edge.

## Test plan
- NUM_PHASES=4, num_iters=1, each child ready 1 cycle after start and done 3 cycles later:
  - child_start pulses in order 0,1,2,3 with zero gaps.
  - Each phase_cycles=5; total_cycles=21.
  - ap_done is a single pulse.
- num_iters=3, single-cycle children (ready=done in the first start cycle):
  - child_start one-hot for 12 consecutive cycles, iter_idx runs 0..2.
  - Each phase_cycles=3; total_cycles=13.
- num_iters=0:
  - ap_done/ap_ready in the cycle after start; child_start never asserted.
  - ap_idle low for exactly 1 cycle.
- Phase 2 stalls child_ready for 10 cycles:
  - child_start[2] held the whole time; phase_cycles[2] includes the stall.
  - No other child_start asserted.
- Spurious child_done[3] injected during phase 1, then ap_rst_n pulled low mid-WAIT:
  - proto_err=1 and the sequence is not advanced.
  - On reset, all outputs return to their reset values asynchronously.
  - A subsequent start runs cleanly with proto_err=0.
- CNT_W=4 with a 20-cycle phase:
  - phase_cycles and total_cycles saturate at 15.
